// File: rtl/id_pkg.sv
// Shared constants and helpers for the decode-slot operand/issue stage.
package id_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int REG0       = 0;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/id_fwd_sel.sv
// Priority forwarding mux for one operand: nearest matching source wins, regfile otherwise.
// Combinational; haz flags a winning source whose result is not yet available.
module id_fwd_sel
    import id_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int NFWD   = 2
) (
    input  logic [REG_AW-1:0]      r,
    input  logic [DATA_W-1:0]      rf_q,
    input  logic [NFWD-1:0]        fwd_wreg,
    input  logic [NFWD*REG_AW-1:0] fwd_rn,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]      val,
    output logic                   haz
);
    logic found;

    always_comb begin
        val   = rf_q;
        haz   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            if (!found && fwd_wreg[i] && fwd_rn[i*REG_AW +: REG_AW] == r
                && r != REG_AW'(REG0)) begin
                found = 1'b1;
                val   = fwd_data[i*DATA_W +: DATA_W];
                haz   = ~fwd_rdy[i];
            end
        end
        if (r == REG_AW'(REG0)) val = '0;
    end
endmodule

// File: rtl/id_operand_issue.sv
// Operand fetch, hazard interlock and ID/EX issue register; one cycle decode-to-ex_*.
// Stalls on not-ready forwards and a long-latency scoreboard; ID_PERF_CNT_EN enables stall_cnt.
module id_operand_issue
    import id_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NFWD     = 2,
    parameter int LONG_LAT = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   id_vld,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_use_rt,
    input  logic                   id_wreg,
    input  logic [REG_AW-1:0]      id_rn,
    input  logic                   id_long,
    input  logic [DATA_W-1:0]      rf_qa,
    input  logic [DATA_W-1:0]      rf_qb,
    input  logic [NFWD-1:0]        fwd_wreg,
    input  logic [NFWD*REG_AW-1:0] fwd_rn,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   flush,
    output logic                   stall,
    output logic                   ex_vld,
    output logic                   ex_wreg,
    output logic                   ex_long,
    output logic [DATA_W-1:0]      ex_a,
    output logic [DATA_W-1:0]      ex_b,
    output logic [REG_AW-1:0]      ex_rn,
    output logic [31:0]            stall_cnt
);
    localparam int NREG = 1 << REG_AW;
    localparam int CW   = clog2(LONG_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(LONG_LAT);

    logic [DATA_W-1:0] val_a, val_b;
    logic              haz_a, haz_b;
    logic [CW-1:0]     sb_cnt [NREG];
    logic [NREG-1:0]   busy;
    logic              issue, sb_load;

    id_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NFWD(NFWD)) u_sel_a (
        .r(id_rs), .rf_q(rf_qa), .fwd_wreg(fwd_wreg), .fwd_rn(fwd_rn),
        .fwd_rdy(fwd_rdy), .fwd_data(fwd_data), .val(val_a), .haz(haz_a)
    );

    id_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NFWD(NFWD)) u_sel_b (
        .r(id_rt), .rf_q(rf_qb), .fwd_wreg(fwd_wreg), .fwd_rn(fwd_rn),
        .fwd_rdy(fwd_rdy), .fwd_data(fwd_data), .val(val_b), .haz(haz_b)
    );

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREG; i++) busy[i] = (sb_cnt[i] != '0);
    end

    // WAW against a busy destination also stalls, so a counter is never reloaded while running.
    assign stall = id_vld & (haz_a | (id_use_rt & haz_b) | busy[id_rs]
                             | (id_use_rt & busy[id_rt]) | (id_wreg & busy[id_rn]));

    assign issue   = id_vld & ~stall & ~flush;
    assign sb_load = issue & id_long & id_wreg & (id_rn != REG_AW'(REG0));

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (sb_load && id_rn == REG_AW'(i)) sb_cnt[i] <= LAT;
                else if (sb_cnt[i] != '0)           sb_cnt[i] <= sb_cnt[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            ex_vld  <= 1'b0;
            ex_wreg <= 1'b0;
            ex_long <= 1'b0;
            ex_a    <= '0;
            ex_b    <= '0;
            ex_rn   <= '0;
        end else if (!issue) begin
            ex_vld  <= 1'b0;
            ex_wreg <= 1'b0;
            ex_long <= 1'b0;
        end else begin
            ex_vld  <= 1'b1;
            ex_wreg <= id_wreg;
            ex_long <= id_long;
            ex_a    <= val_a;
            ex_b    <= val_b;
            ex_rn   <= id_rn;
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn)                              stall_cnt <= '0;
        else if (stall && stall_cnt != '1)     stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_id_operand_issue.sv
// Directed bench for id_operand_issue with default parameters (32b data, 5b regs, 2 forwards, LONG_LAT=4).
module tb_id_operand_issue;
    logic        clk = 1'b0;
    logic        clrn;
    logic        id_vld, id_use_rt, id_wreg, id_long, flush;
    logic [4:0]  id_rs, id_rt, id_rn;
    logic [31:0] rf_qa, rf_qb;
    logic [1:0]  fwd_wreg, fwd_rdy;
    logic [9:0]  fwd_rn;
    logic [63:0] fwd_data;
    logic        stall, ex_vld, ex_wreg, ex_long;
    logic [31:0] ex_a, ex_b, stall_cnt;
    logic [4:0]  ex_rn;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stalls = 0;

    id_operand_issue dut (
        .clk(clk), .clrn(clrn), .id_vld(id_vld), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn), .id_long(id_long),
        .rf_qa(rf_qa), .rf_qb(rf_qb), .fwd_wreg(fwd_wreg), .fwd_rn(fwd_rn),
        .fwd_rdy(fwd_rdy), .fwd_data(fwd_data), .flush(flush), .stall(stall),
        .ex_vld(ex_vld), .ex_wreg(ex_wreg), .ex_long(ex_long), .ex_a(ex_a),
        .ex_b(ex_b), .ex_rn(ex_rn), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef ID_PERF_CNT_EN
        return 32'(exp_stalls);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        clrn = 1'b1; id_vld = 0; id_use_rt = 0; id_wreg = 0; id_long = 0; flush = 0;
        id_rs = 0; id_rt = 0; id_rn = 0; rf_qa = 0; rf_qb = 0;
        fwd_wreg = 0; fwd_rdy = 0; fwd_rn = 0; fwd_data = 0;
        tick(); tick();
        check("rst_ex_vld", ex_vld, 0);
        check("rst_ex_a", ex_a, 0);
        check("rst_ex_rn", ex_rn, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        clrn = 1'b0;
        tick();

        // 1: both sources write r5, nearest wins
        id_vld = 1; id_rs = 5; id_rt = 6; id_use_rt = 1; id_wreg = 1; id_rn = 9;
        rf_qa = 32'hAAAA; rf_qb = 32'hBBBB;
        fwd_wreg = 2'b11; fwd_rn = {5'd5, 5'd5}; fwd_rdy = 2'b11;
        fwd_data = {32'h22, 32'h11};
        #1 check("prio_stall", stall, 0);
        tick();
        check("prio_ex_vld", ex_vld, 1);
        check("prio_ex_a", ex_a, 32'h11);
        check("prio_ex_b_rf", ex_b, 32'hBBBB);
        check("prio_ex_rn", ex_rn, 9);
        check("prio_ex_wreg", ex_wreg, 1);

        // 1b: nearest ready shadows a not-ready farther source; rt comes from source 1
        fwd_rn = {5'd6, 5'd5}; fwd_rdy = 2'b01;
        #1 check("prio_shadow_stall", stall, 1);
        exp_stalls++;
        tick();
        check("prio_shadow_ex_vld", ex_vld, 0);
        fwd_rdy = 2'b11;
        #1 check("fwd1_stall", stall, 0);
        tick();
        check("fwd1_ex_a", ex_a, 32'h11);
        check("fwd1_ex_b", ex_b, 32'h22);

        // 2: load-use on rt
        fwd_wreg = 2'b01; fwd_rn = {5'd0, 5'd3}; fwd_rdy = 2'b00;
        id_rs = 1; id_rt = 3; id_use_rt = 1; rf_qa = 32'h1234;
        #1 check("lu_stall", stall, 1);
        exp_stalls++;
        tick();
        check("lu_ex_vld", ex_vld, 0);
        check("lu_ex_a_hold", ex_a, 32'h11);
        id_use_rt = 0;
        #1 check("lu_imm_stall", stall, 0);
        tick();
        check("lu_imm_ex_vld", ex_vld, 1);
        check("lu_imm_ex_a", ex_a, 32'h1234);

        // 3: long op to r7, then a reader of r7
        fwd_wreg = 0; id_use_rt = 1; id_rs = 1; id_rt = 2; id_rn = 7; id_long = 1;
        #1 check("long_issue_stall", stall, 0);
        tick();
        check("long_ex_long", ex_long, 1);
        id_long = 0; id_rs = 7; id_rn = 8; rf_qa = 32'h7777;
        for (int c = 0; c < 4; c++) begin
            #1 check($sformatf("long_stall_c%0d", c + 1), stall, 1);
            exp_stalls++;
            tick();
            check($sformatf("long_ex_vld_c%0d", c + 1), ex_vld, 0);
        end
        #1 check("long_release_stall", stall, 0);
        tick();
        check("long_release_ex_vld", ex_vld, 1);
        check("long_release_ex_a", ex_a, 32'h7777);
        check("long_release_ex_long", ex_long, 0);

        // 4: register zero ignores forwarding and regfile
        fwd_wreg = 2'b01; fwd_rn = {5'd0, 5'd0}; fwd_rdy = 2'b00;
        fwd_data = {32'h0, 32'hFF}; id_rs = 0; id_rt = 0; rf_qa = 32'hDEAD; id_rn = 4;
        #1 check("r0_stall", stall, 0);
        tick();
        check("r0_ex_a", ex_a, 0);
        check("r0_ex_vld", ex_vld, 1);
        fwd_wreg = 0;

        // 5: flush over a stalled long op
        id_rs = 1; id_rt = 2; id_rn = 7; id_long = 1; rf_qa = 32'h5;
        tick();
        id_rs = 7; id_rn = 10; flush = 1;
        #1 check("flush_stall", stall, 1);
        exp_stalls++;
        tick();
        check("flush_ex_vld", ex_vld, 0);
        check("flush_ex_long", ex_long, 0);
        check("flush_stall_cnt", stall_cnt, exp_cnt());
        flush = 0; id_long = 0; id_rs = 10; id_rt = 0; id_rn = 11; rf_qa = 32'hA0;
        #1 check("flush_no_sb_stall", stall, 0);
        tick();
        check("flush_no_sb_ex_a", ex_a, 32'hA0);

        // 6: async reset mid-countdown (r7 still busy)
        id_rs = 7; id_rn = 12; rf_qa = 32'hC7;
        #1 check("pre_rst_stall", stall, 1);
        clrn = 1; #2 clrn = 0; #1;
        check("arst_ex_vld", ex_vld, 0);
        check("arst_ex_a", ex_a, 0);
        check("arst_ex_rn", ex_rn, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_stall", stall, 0);
        tick();
        check("arst_issue_ex_vld", ex_vld, 1);
        check("arst_issue_ex_a", ex_a, 32'hC7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
